// File: rtl/mtsp_sf_wb_pkg.sv
// Shared types for the MTSP special-function writeback buffer.
// MTSP_SF_WB_MERGE_EN adds the second dword and phase-#0 lane mask to each entry.
package mtsp_sf_wb_pkg;

   localparam int LANE_X = 3;
   localparam int LANE_Y = 2;
   localparam int LANE_Z = 1;
   localparam int LANE_W = 0;

   localparam int WB_ADDR_W = 6;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [3:0]           mask;
`ifdef MTSP_SF_WB_MERGE_EN
      logic [3:0]           mask0;
      logic [31:0]          dword1;
`endif
      logic [31:0]          dword0;
   } wb_entry_t;

   function automatic logic [31:0] lane_dword(wb_entry_t e, int lane);
`ifdef MTSP_SF_WB_MERGE_EN
      return e.mask0[lane] ? e.dword0 : e.dword1;
`else
      return (lane >= 0) ? e.dword0 : 32'h0;
`endif
   endfunction

   function automatic logic [127:0] expand_lanes(wb_entry_t e);
      logic [127:0] r;
      r = '0;
      r[LANE_X*32 +: 32] = lane_dword(e, LANE_X);
      r[LANE_Y*32 +: 32] = lane_dword(e, LANE_Y);
      r[LANE_Z*32 +: 32] = lane_dword(e, LANE_Z);
      r[LANE_W*32 +: 32] = lane_dword(e, LANE_W);
      return r;
   endfunction

endpackage

// File: rtl/mtsp_sf_wb_fifo.sv
// Two-write / one-read queue of writeback entries.
// Writer must use slot 0 before slot 1; slot 1 lands right behind slot 0.
module mtsp_sf_wb_fifo
   import mtsp_sf_wb_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en0,
   input  wb_entry_t        wr_data0,
   input  logic             wr_en1,
   input  wb_entry_t        wr_data1,
   input  logic             rd_en,
   output wb_entry_t        rd_data,
   output logic [CNT_W-1:0] count
);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;

   // Storage is reset so the outputs read back zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en0) mem[wptr] <= wr_data0;
         if (wr_en1) mem[wptr + PTR_W'(1)] <= wr_data1;
         wptr  <= wptr + PTR_W'(wr_en0) + PTR_W'(wr_en1);
         if (rd_en) rptr <= rptr + PTR_W'(1);
         count <= count + CNT_W'(wr_en0) + CNT_W'(wr_en1) - CNT_W'(rd_en);
      end
   end

   assign rd_data = mem[rptr];

endmodule

// File: rtl/mtsp_sf_wb.sv
// Special-function writeback buffer: queues up to two SF results per cycle and
// drains them through one arbitrated RF write port. Optional: MTSP_SF_WB_MERGE_EN.
module mtsp_sf_wb
   import mtsp_sf_wb_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int ADDR_W      = 6,
   parameter int HOLD_MARGIN = 6
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [3:0]        WE0,
   input  logic [31:0]       DOUT0,
   input  logic [ADDR_W-1:0] DST0,
   input  logic [3:0]        WE1,
   input  logic [31:0]       DOUT1,
   input  logic [ADDR_W-1:0] DST1,
   output logic              RF_REQ,
   input  logic              RF_GNT,
   output logic [ADDR_W-1:0] RF_ADDR,
   output logic [3:0]        RF_WMASK,
   output logic [127:0]      RF_WDATA,
   output logic              ISSUE_HOLD,
   output logic              OVF
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int CW    = CNT_W + 1;

   wb_entry_t      ent0, ent1, first_ent, head;
   logic           has_first, has_second, pop;
   logic           wr_en0, wr_en1, ovf_set;
   logic [CNT_W-1:0] count;
   logic [CW-1:0]  free_slots, count_next;

   always_comb begin
      ent0        = '0;
      ent0.addr   = WB_ADDR_W'(DST0);
      ent0.mask   = WE0;
      ent0.dword0 = DOUT0;
      ent1        = '0;
      ent1.addr   = WB_ADDR_W'(DST1);
      ent1.mask   = WE1;
      ent1.dword0 = DOUT1;
      has_first   = (WE0 != 4'h0) || (WE1 != 4'h0);
      has_second  = (WE0 != 4'h0) && (WE1 != 4'h0);
`ifdef MTSP_SF_WB_MERGE_EN
      ent0.mask0  = WE0;
      ent0.dword1 = DOUT0;
      ent1.mask0  = WE1;
      ent1.dword1 = DOUT1;
      // Disjoint lanes to the same register fold into one entry and one slot.
      if (has_second && (DST0 == DST1) && ((WE0 & WE1) == 4'h0)) begin
         ent0.mask   = WE0 | WE1;
         ent0.dword1 = DOUT1;
         has_second  = 1'b0;
      end
`endif
      first_ent = (WE0 != 4'h0) ? ent0 : ent1;
   end

   assign RF_REQ = (count != '0);
   assign pop    = RF_REQ & RF_GNT;

   // A same-cycle pop frees a slot, so push+pop on a full queue never overflows.
   assign free_slots = CW'(DEPTH) - CW'(count) + CW'(pop);
   assign wr_en0     = has_first  && (free_slots >= CW'(1));
   assign wr_en1     = has_second && (free_slots >= CW'(2));
   assign ovf_set    = (has_first && !wr_en0) || (has_second && !wr_en1);
   assign count_next = CW'(count) + CW'(wr_en0) + CW'(wr_en1) - CW'(pop);

   mtsp_sf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (CLK),
      .rst_n    (nRST),
      .wr_en0   (wr_en0),
      .wr_data0 (first_ent),
      .wr_en1   (wr_en1),
      .wr_data1 (ent1),
      .rd_en    (pop),
      .rd_data  (head),
      .count    (count)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ISSUE_HOLD <= 1'b0;
         OVF        <= 1'b0;
      end else begin
         ISSUE_HOLD <= (count_next > CW'(DEPTH - HOLD_MARGIN));
         if (ovf_set) OVF <= 1'b1;
      end
   end

   assign RF_ADDR  = ADDR_W'(head.addr);
   assign RF_WMASK = head.mask;
   assign RF_WDATA = expand_lanes(head);

endmodule

// File: tb/tb_mtsp_sf_wb.sv
// Self-checking bench for mtsp_sf_wb: vector table plus corner-case sequences,
// all outputs compared against a scoreboard queue of expected RF writes.
module tb_mtsp_sf_wb;

   localparam int DEPTH       = 8;
   localparam int ADDR_W      = 6;
   localparam int HOLD_MARGIN = 6;

   logic              CLK = 1'b0;
   logic              nRST;
   logic [3:0]        WE0, WE1;
   logic [31:0]       DOUT0, DOUT1;
   logic [ADDR_W-1:0] DST0, DST1;
   logic              RF_REQ, RF_GNT;
   logic [ADDR_W-1:0] RF_ADDR;
   logic [3:0]        RF_WMASK;
   logic [127:0]      RF_WDATA;
   logic              ISSUE_HOLD, OVF;

   always #5 CLK = ~CLK;

   mtsp_sf_wb #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD_MARGIN(HOLD_MARGIN)) dut (
      .CLK(CLK), .nRST(nRST),
      .WE0(WE0), .DOUT0(DOUT0), .DST0(DST0),
      .WE1(WE1), .DOUT1(DOUT1), .DST1(DST1),
      .RF_REQ(RF_REQ), .RF_GNT(RF_GNT), .RF_ADDR(RF_ADDR),
      .RF_WMASK(RF_WMASK), .RF_WDATA(RF_WDATA),
      .ISSUE_HOLD(ISSUE_HOLD), .OVF(OVF)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [3:0]        mask;
      logic [127:0]      data;
   } exp_t;

   typedef struct {
      logic [3:0]        we0;
      logic [31:0]       d0;
      logic [ADDR_W-1:0] a0;
      logic [3:0]        we1;
      logic [31:0]       d1;
      logic [ADDR_W-1:0] a1;
      logic [ADDR_W-1:0] exp_addr;
      logic [3:0]        exp_mask;
      logic [127:0]      exp_data;
      int                exp_n;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic exp_hold = 1'b0;
   logic exp_ovf  = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [ADDR_W-1:0] a, input logic [3:0] m,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [3:0] sel0);
      exp_t e;
      e.addr = a;
      e.mask = m;
      for (int i = 0; i < 4; i++) e.data[i*32 +: 32] = sel0[i] ? d0 : d1;
      return e;
   endfunction

   task automatic set_in(input logic [3:0] w0, input logic [31:0] d0, input logic [ADDR_W-1:0] a0,
                         input logic [3:0] w1, input logic [31:0] d1, input logic [ADDR_W-1:0] a1);
      WE0 = w0; DOUT0 = d0; DST0 = a0;
      WE1 = w1; DOUT1 = d1; DST1 = a1;
   endtask

   task automatic idle();
      set_in(4'h0, 32'h0, '0, 4'h0, 32'h0, '0);
   endtask

   // One clock: check outputs against the model at the falling edge, then
   // apply the currently driven inputs to the model, then step past the edge.
   task automatic cycle();
      exp_t nq[$];
      bit   mg;
      @(negedge CLK);
      if (!nRST) begin
         sb.delete();
         exp_hold = 1'b0;
         exp_ovf  = 1'b0;
         chk("rst_req", RF_REQ, 0);
      end else begin
         chk("req", RF_REQ, sb.size() != 0);
         if (sb.size() != 0) begin
            chk("addr", RF_ADDR, sb[0].addr);
            chk("mask", RF_WMASK, sb[0].mask);
            chk("data", RF_WDATA, sb[0].data);
         end
         chk("hold", ISSUE_HOLD, exp_hold);
         chk("ovf", OVF, exp_ovf);
         if (sb.size() != 0 && RF_GNT) void'(sb.pop_front());
         mg = 1'b0;
`ifdef MTSP_SF_WB_MERGE_EN
         mg = (WE0 != 0) && (WE1 != 0) && (DST0 == DST1) && ((WE0 & WE1) == 0);
`endif
         if (mg) nq.push_back(mk(DST0, WE0 | WE1, DOUT0, DOUT1, WE0));
         else begin
            if (WE0 != 0) nq.push_back(mk(DST0, WE0, DOUT0, DOUT0, 4'hF));
            if (WE1 != 0) nq.push_back(mk(DST1, WE1, DOUT1, DOUT1, 4'hF));
         end
         foreach (nq[i]) begin
            if (sb.size() < DEPTH) sb.push_back(nq[i]);
            else exp_ovf = 1'b1;
         end
         exp_hold = (sb.size() > DEPTH - HOLD_MARGIN);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic drain(output int nreq);
      nreq = 0;
      idle();
      RF_GNT = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (!RF_REQ && sb.size() == 0) return;
         if (RF_REQ) nreq++;
         cycle();
      end
      checks++;
      errors++;
      $display("FAIL drain_timeout: model still holds %0d entries, RF_REQ=%0b", sb.size(), RF_REQ);
   endtask

   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int nreq;
      localparam logic [31:0] A = 32'hAAAA_0001;
      localparam logic [31:0] B = 32'hBBBB_0002;

      vecs[0] = '{4'b1010, 32'h3F80_0000, 6'd5, 4'b0000, 32'h0, 6'd0,
                  6'd5, 4'b1010, {4{32'h3F80_0000}}, 1};
      vecs[1] = '{4'b1000, 32'h1111_1111, 6'd2, 4'b0001, 32'h2222_2222, 6'd3,
                  6'd2, 4'b1000, {4{32'h1111_1111}}, 2};
      vecs[2] = '{4'b0000, 32'h0, 6'd0, 4'b0110, 32'hDEAD_BEEF, 6'd9,
                  6'd9, 4'b0110, {4{32'hDEAD_BEEF}}, 1};
`ifdef MTSP_SF_WB_MERGE_EN
      vecs[3] = '{4'b1100, A, 6'd7, 4'b0011, B, 6'd7,
                  6'd7, 4'b1111, {A, A, B, B}, 1};
`else
      vecs[3] = '{4'b1100, A, 6'd7, 4'b0011, B, 6'd7,
                  6'd7, 4'b1100, {4{A}}, 2};
`endif
      vecs[4] = '{4'b1100, 32'h1234_5678, 6'd7, 4'b0110, 32'h8765_4321, 6'd7,
                  6'd7, 4'b1100, {4{32'h1234_5678}}, 2};
      vecs[5] = '{4'b0000, 32'hFFFF_FFFF, 6'd1, 4'b0000, 32'hEEEE_EEEE, 6'd1,
                  6'd0, 4'b0000, 128'h0, 0};

      // Reset values
      nRST = 1'b0;
      RF_GNT = 1'b0;
      idle();
      #2;
      cycle();
      cycle();
      chk("rst_addr", RF_ADDR, 0);
      chk("rst_wmask", RF_WMASK, 0);
      chk("rst_wdata", RF_WDATA, 0);
      chk("rst_hold", ISSUE_HOLD, 0);
      chk("rst_ovf", OVF, 0);
      nRST = 1'b1;
      cycle();
      chk("post_rst_req", RF_REQ, 0);

      // Vector table, each applied to an empty queue with grant held high
      foreach (vecs[k]) begin
         RF_GNT = 1'b1;
         set_in(vecs[k].we0, vecs[k].d0, vecs[k].a0, vecs[k].we1, vecs[k].d1, vecs[k].a1);
         cycle();
         if (vecs[k].exp_n > 0) begin
            chk($sformatf("vec%0d_req", k), RF_REQ, 1);
            chk($sformatf("vec%0d_addr", k), RF_ADDR, vecs[k].exp_addr);
            chk($sformatf("vec%0d_mask", k), RF_WMASK, vecs[k].exp_mask);
            chk($sformatf("vec%0d_data", k), RF_WDATA, vecs[k].exp_data);
         end else begin
            chk($sformatf("vec%0d_req", k), RF_REQ, 0);
         end
         drain(nreq);
         chk($sformatf("vec%0d_nreq", k), nreq, vecs[k].exp_n);
      end

      // Full queue, then one push per cycle with grant: no overflow, stays full
      RF_GNT = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_in(4'b1111, 32'h1000_0000 + i, ADDR_W'(2*i), 4'b0101, 32'h2000_0000 + i, ADDR_W'(2*i+1));
         cycle();
      end
      chk("full_hold", ISSUE_HOLD, 1);
      RF_GNT = 1'b1;
      for (int i = 0; i < 6; i++) begin
         set_in(4'b0011, 32'h3000_0000 + i, ADDR_W'(20+i), 4'b0000, 32'h0, '0);
         cycle();
         chk("fullpp_req", RF_REQ, 1);
      end
      chk("fullpp_ovf", OVF, 0);
      drain(nreq);
      chk("fullpp_nreq", nreq, 8);

      // Back-pressure and overflow: two pushes per cycle with no grant
      RF_GNT = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_in(4'b1000, 32'h4000_0000 + i, ADDR_W'(30+2*i), 4'b0001, 32'h5000_0000 + i, ADDR_W'(31+2*i));
         cycle();
         if (i == 0) chk("bp_hold_c2", ISSUE_HOLD, 0);
         if (i == 1) chk("bp_hold_c4", ISSUE_HOLD, 1);
         if (i == 3) chk("bp_ovf_c8", OVF, 0);
      end
      chk("bp_ovf", OVF, 1);
      drain(nreq);
      chk("bp_nreq", nreq, 8);
      chk("bp_ovf_sticky", OVF, 1);

      // Reset with four entries queued
      RF_GNT = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_in(4'b1001, 32'h6000_0000 + i, ADDR_W'(40+i), 4'b0110, 32'h7000_0000 + i, ADDR_W'(50+i));
         cycle();
      end
      chk("mid_req_before", RF_REQ, 1);
      idle();
      nRST = 1'b0;
      #1;
      chk("mid_rst_req", RF_REQ, 0);
      chk("mid_rst_ovf", OVF, 0);
      cycle();
      nRST = 1'b1;
      RF_GNT = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      chk("mid_post_req", RF_REQ, 0);
      set_in(4'b0100, 32'hCAFE_F00D, 6'd33, 4'b0000, 32'h0, '0);
      cycle();
      chk("mid_new_req", RF_REQ, 1);
      chk("mid_new_addr", RF_ADDR, 33);
      drain(nreq);
      chk("mid_new_nreq", nreq, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
